serial_receive: RTL

UART-style receiver that is the downstream peer of the 16-bit serial transmitter and consumes its serial line. Frame format: idle high, one start bit (low), 16 data bits LSB first, one stop bit (high). The receiver oversamples the line, recovers the word, and holds it for the consumer under a ready/ack handshake. It reports framing errors and overruns.

---
 rtl/serial_receive_pkg.sv | 20 ++
 rtl/serial_receive_if.sv | 28 ++
 rtl/serial_rx_sync.sv | 25 ++
 rtl/serial_receive.sv | 130 +++++++++++++
 4 files changed

// File: rtl/serial_receive_pkg.sv
// Shared definitions for the serial link: default frame geometry and receiver state encoding.
// Latency: n/a; backpressure: n/a.
package serial_receive_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    function automatic int tick_width(input int oversample);
        return (oversample > 1) ? $clog2(oversample) : 1;
    endfunction

endpackage

// File: rtl/serial_receive_if.sv
// Consumer-facing bundle of the serial receiver: oversample tick, line, handshake and status.
// Latency: n/a; backpressure: Ack retires DataReady, no stall of the line itself.
interface serial_receive_if
    import serial_receive_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic                 SampleTick;
    logic                 Receive;
    logic                 Ack;
    logic [DATA_BITS-1:0] DataOut;
    logic                 DataReady;
    logic                 FrameError;
    logic                 Overrun;
    logic                 Busy;

    modport master (
        output SampleTick, Receive, Ack,
        input  DataOut, DataReady, FrameError, Overrun, Busy
    );

    modport slave (
        input  SampleTick, Receive, Ack,
        output DataOut, DataReady, FrameError, Overrun, Busy
    );

endinterface

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, resetting to the idle (high) level.
// Latency: 2 Clock cycles; backpressure: none.
module serial_rx_sync (
    input  logic Clock,
    input  logic Reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_receive.sv
// Oversampling UART receiver: start/DATA_BITS LSB-first/stop framing, word held under ready/ack.
// Latency: ~1.5+DATA_BITS bit periods + 2 Clocks from start edge; backpressure: none, unacked words are overwritten (Overrun).
module serial_receive
    import serial_receive_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic           Clock,
    input  logic           Reset_n,
    serial_receive_if.slave bus
);

    localparam int              TW        = tick_width(OVERSAMPLE);
    localparam logic [TW-1:0]   MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [4:0]      LAST_BIT  = 5'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [TW-1:0]        tick_cnt_d;
    logic [4:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] sr_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 ready_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 word_done;

    serial_rx_sync u_sync (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .d_i     (bus.Receive),
        .q_o     (rx_s)
    );

    assign tick_cnt_d = tick_cnt_q + TW'(1);
    assign sr_d       = {rx_s, sr_q[DATA_BITS-1:1]};
    assign word_done  = bus.SampleTick && (state_q == STOP) && (tick_cnt_q == LAST_TICK) && rx_s;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            // A completing word beats a same-cycle Ack: the fresh word stays pending.
            if (word_done) begin
                data_q  <= sr_q;
                ready_q <= 1'b1;
                ovr_q   <= ready_q & ~bus.Ack;
            end else if (bus.Ack) begin
                ready_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (bus.SampleTick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt_q == MID_START) begin
                            if (!rx_s) begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_q == LAST_TICK) begin
                            sr_q       <= sr_d;
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_q == LAST_TICK) begin
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                    // A line stuck low after a bad stop bit must not look like a new start edge.
                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.DataOut    = data_q;
    assign bus.DataReady  = ready_q;
    assign bus.FrameError = ferr_q;
    assign bus.Overrun    = ovr_q;
    assign bus.Busy       = (state_q != IDLE);

endmodule
